ay_write_seq: RTL and testbench
===============================

Name: ay_write_seq

Overview:
- Command sequencer that sits between a producer and the ay3891x PSG write port. Producers are the CPU I/O shim or a tune-player ROM walker.
- Buffers register-write commands in a FIFO and replays each one as the PSG two-phase write protocol: address phase, then data phase.
- Supports frame-timed delay commands, so a tune stream can be pushed without CPU pacing.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the delay counter in frame ticks; the delay argument is the 8-bit data field, zero-extended.

Ports:
- clk  in  1  system clock (25 MHz)
- reset  in  1  asynchronous, active-high reset
- push  in  1  single-cycle strobe; enqueue cmd
- cmd  in  13  bit12 = DELAY flag; bits11:8 = PSG register number; bits7:0 = data, or frame count when DELAY=1
- flush  in  1  single-cycle strobe; discard queued commands
- frame_tick  in  1  single-cycle pulse (e.g. 50/60 Hz) used by delay commands
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- busy  out  1  sequencer not in IDLE, or FIFO non-empty
- overflow  out  1  sticky; a push arrived while full
- a0  out  1  to PSG: 0 = address phase, 1 = data phase
- wr_tick  out  1  to PSG write strobe
- wdata  out  8  to PSG write data

Behaviour:
- Reset (async, active-high) forces the following; all other outputs are registered.
  - FIFO empty, state IDLE, delay counter 0.
  - a0=0, wr_tick=0, wdata=0.
  - overflow=0, full=0, empty=1, busy=0.
- FIFO:
  - push with !full enqueues at the clk edge.
  - push with full is dropped and sets overflow. overflow clears only on reset or flush.
  - A pop and a push in the same cycle are both honoured. When full, push is still dropped, because full is sampled pre-edge.
- State machine: IDLE, ADDR, DATA, GAP, WAIT.
  - IDLE: if !empty, pop the head into a holding register.
    - DELAY=0: go to ADDR.
    - DELAY=1 with data!=0: go to WAIT and load the counter with data.
    - DELAY=1 with data==0: stay in IDLE; the command is consumed as a no-op.
  - ADDR (1 cycle): a0=0, wr_tick=1, wdata={4'h0, reg}. Next state is DATA.
  - DATA (1 cycle): a0=1, wr_tick=1, wdata=data. Next state is GAP.
  - GAP (1 cycle): wr_tick=0, a0=0, wdata=0.
    - If !empty, pop and branch exactly as from IDLE (ADDR, WAIT or no-op).
    - Otherwise go to IDLE.
  - WAIT: each frame_tick decrements the counter. The cycle in which the counter would reach 0 goes to IDLE.
    - A frame_tick in the same cycle as WAIT is entered is not counted.
    - A delay of N therefore waits for exactly N subsequent frame_ticks.
- Timing:
  - Push into an empty, idle sequencer at edge E0: wr_tick/a0=0 are visible after edge E2, and the data phase follows after edge E3.
  - Sustained throughput is one register write per 3 clocks (ADDR, DATA, GAP).
- flush:
  - Empties the FIFO and clears overflow.
  - WAIT goes to IDLE on the next edge.
  - An ADDR/DATA pair already in progress always completes, so the PSG address latch is never left half-written by flush.
  - push in the same cycle as flush is discarded.
- Reset mid-pair aborts immediately; the outputs drop to 0 asynchronously.
- Registers 14/15 are not special-cased; they are written like any other register.

Optional Feature:
- AY_WRITE_SEQ_SHADOW_EN
  - Defined: adds ports shadow_addr (in, 4) and shadow_data (out, 8). A 16x8 shadow register file is updated in the DATA state with the value written to reg. shadow_data is a combinational read of shadow_addr. The shadow file resets to 0.
  - Undefined: neither the ports nor the storage exist.

Decomposition:
- Package ay_write_seq_pkg:
  - state enum (IDLE, ADDR, DATA, GAP, WAIT);
  - CMD_W=13 and the field positions CMD_DELAY_BIT=12, CMD_REG_MSB=11, CMD_REG_LSB=8;
  - NUM_PSG_REGS=16.
- Sub-module ay_cmd_fifo: synchronous FIFO with WIDTH and DEPTH parameters, providing push, pop, head, full and empty.

Test Plan:
- Reset then push {0,4'h0,8'h21}: one ADDR cycle (a0=0, wdata=0x00, wr_tick=1), then DATA (a0=1, wdata=0x21), then wr_tick=0. busy falls one cycle after GAP.
- Push 4 writes back-to-back (R0=0x21, R1=0x0F, R8=0x0F, R7=0x07): wr_tick follows the 1,1,0 pattern ×4 with no extra idle cycles. The PSG model reads channel A period 0xF21.
- Push {1,4'h0,8'h03}, then the R9=0x0F write, with frame_tick every 100 clocks: the R9 write starts exactly after the 3rd counted frame_tick. A DELAY with data 0 produces no wait.
- Push DEPTH+1 commands while blocked in a long WAIT: full=1, overflow=1, and the extra command is never emitted. flush clears overflow and empty=1, and WAIT exits.
- Assert flush during an ADDR cycle: the DATA phase still completes and the remaining queue is discarded. Assert reset during DATA: wr_tick=0 immediately.
- With AY_WRITE_SEQ_SHADOW_EN defined: write R13=0x02, then set shadow_addr=13; shadow_data=0x02, and unwritten registers read 0x00.

Source files
------------

// File: rtl/ay_write_seq_pkg.sv
// Shared definitions for the AY PSG write sequencer: FSM states and
// command field layout.
package ay_write_seq_pkg;

  localparam int CMD_W         = 13;
  localparam int CMD_DELAY_BIT = 12;
  localparam int CMD_REG_MSB   = 11;
  localparam int CMD_REG_LSB   = 8;
  localparam int NUM_PSG_REGS  = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    GAP  = 3'd3,
    WAIT = 3'd4
  } state_t;

endpackage

// File: rtl/ay_cmd_fifo.sv
// Synchronous command FIFO. flush wins over push and pop in the same cycle;
// full/empty come straight from the occupancy register.
module ay_cmd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;
  assign head  = mem[rd_ptr];

  // Storage array; no reset needed, occupancy tracking guards reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ay_write_seq.sv
// AY-3-891x write sequencer: queues register writes / frame delays and
// replays writes as an address phase followed by a data phase.
// PSG-facing outputs are registered from the current state, so they trail
// the FSM by one cycle; a pair already started therefore always completes.
// Optional build macro: AY_WRITE_SEQ_SHADOW_EN adds a readable 16x8 shadow
// copy of every register written.
module ay_write_seq
  import ay_write_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [CMD_W-1:0] cmd,
  input  logic             flush,
  input  logic             frame_tick,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             overflow,
  output logic             a0,
  output logic             wr_tick,
  output logic [7:0]       wdata
`ifdef AY_WRITE_SEQ_SHADOW_EN
  ,
  input  logic [3:0]       shadow_addr,
  output logic [7:0]       shadow_data
`endif
);

  state_t           state;
  logic [CMD_W-1:0] head;
  logic             pop;
  logic             h_delay;
  logic [3:0]       h_reg;
  logic [7:0]       h_data;
  logic [3:0]       hold_reg;
  logic [7:0]       hold_data;
  logic [CNT_W-1:0] cnt;

  ay_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (cmd),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign h_delay = head[CMD_DELAY_BIT];
  assign h_reg   = head[CMD_REG_MSB:CMD_REG_LSB];
  assign h_data  = head[7:0];
  assign pop     = !empty && !flush && (state == IDLE || state == GAP);
  assign busy    = (state != IDLE) || !empty;

  // Sticky overflow: a push seen while full; cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              overflow <= 1'b0;
    else if (flush)         overflow <= 1'b0;
    else if (push && full)  overflow <= 1'b1;
  end

  // Sequencer FSM with PSG outputs registered from the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold_reg  <= '0;
      hold_data <= '0;
      cnt       <= '0;
      a0        <= 1'b0;
      wr_tick   <= 1'b0;
      wdata     <= '0;
    end else begin
      a0      <= (state == DATA);
      wr_tick <= (state == ADDR) || (state == DATA);
      wdata   <= (state == ADDR) ? {4'h0, hold_reg} :
                 (state == DATA) ? hold_data : 8'h00;
      case (state)
        IDLE, GAP: begin
          if (pop) begin
            hold_reg  <= h_reg;
            hold_data <= h_data;
            if (!h_delay) begin
              state <= ADDR;
            end else if (h_data != 8'h00) begin
              state <= WAIT;
              cnt   <= CNT_W'(h_data);
            end else begin
              state <= IDLE;  // zero-length delay is a no-op
            end
          end else begin
            state <= IDLE;
          end
        end
        ADDR: state <= DATA;
        DATA: state <= GAP;
        WAIT: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (frame_tick) begin
            if (cnt <= CNT_W'(1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AY_WRITE_SEQ_SHADOW_EN
  logic [7:0] shadow [NUM_PSG_REGS];

  // Shadow copy captured while the data phase is being issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PSG_REGS; i++) shadow[i] <= '0;
    end else if (state == DATA) begin
      shadow[hold_reg] <= hold_data;
    end
  end

  assign shadow_data = shadow[shadow_addr];
`endif

endmodule

// File: tb/tb_ay_write_seq.sv
// Scoreboard bench for ay_write_seq: stimulus pushes expected writes,
// a negedge monitor reassembles address/data pairs and compares.
module tb_ay_write_seq;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic        flush = 1'b0;
  logic        frame_tick = 1'b0;
  logic [12:0] cmd = '0;
  logic        full, empty, busy, overflow, a0, wr_tick;
  logic [7:0]  wdata;
`ifdef AY_WRITE_SEQ_SHADOW_EN
  logic [3:0]  shadow_addr = '0;
  logic [7:0]  shadow_data;
`endif

  ay_write_seq #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .cmd        (cmd),
    .flush      (flush),
    .frame_tick (frame_tick),
    .full       (full),
    .empty      (empty),
    .busy       (busy),
    .overflow   (overflow),
    .a0         (a0),
    .wr_tick    (wr_tick),
    .wdata      (wdata)
`ifdef AY_WRITE_SEQ_SHADOW_EN
    ,
    .shadow_addr(shadow_addr),
    .shadow_data(shadow_data)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  psg [16];
  logic [15:0] hist = '0;
  logic        addr_pend = 1'b0;
  logic [7:0]  cur_reg = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_cmd(input logic [12:0] c, input bit expect_out);
    push = 1'b1;
    cmd  = c;
    if (expect_out) exp_q.push_back(c[11:0]);
    @(negedge clk);
    push = 1'b0;
  endtask

  // Monitor: rebuild PSG writes from the two-phase protocol and score them.
  always @(negedge clk) begin
    hist = {hist[14:0], wr_tick};
    if (reset) begin
      addr_pend = 1'b0;
    end else if (wr_tick) begin
      if (!a0) begin
        if (addr_pend) chk("double_addr_phase", 32'd1, 32'd0);
        addr_pend = 1'b1;
        cur_reg   = wdata;
      end else begin
        if (!addr_pend) begin
          chk("data_without_addr", 32'd1, 32'd0);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_write", {20'h0, cur_reg[3:0], wdata}, 32'hFFFF_FFFF);
        end else begin
          chk("psg_write", {20'h0, cur_reg[3:0], wdata}, {20'h0, exp_q.pop_front()});
        end
        psg[cur_reg[3:0]] = wdata;
        n_writes++;
        addr_pend = 1'b0;
      end
    end else if (addr_pend) begin
      chk("data_phase_missing", 32'd1, 32'd0);
      addr_pend = 1'b0;
    end
  end

  // Bound the run so a stuck design still ends with a report.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    for (int i = 0; i < 16; i++) psg[i] = 8'h00;
    #2 reset = 1'b1;
    step(2);
    chk("rst_a0", a0, 0);
    chk("rst_wr_tick", wr_tick, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step(1);

    // Single write: latency and phase contents.
    push_cmd(13'h0021, 1);
    chk("t1_busy_e0", busy, 1);
    chk("t1_empty_e0", empty, 0);
    chk("t1_wr_e0", wr_tick, 0);
    step(1);
    chk("t1_wr_e1", wr_tick, 0);
    step(1);
    chk("t1_wr_e2", wr_tick, 1);
    chk("t1_a0_e2", a0, 0);
    chk("t1_wdata_e2", wdata, 8'h00);
    step(1);
    chk("t1_wr_e3", wr_tick, 1);
    chk("t1_a0_e3", a0, 1);
    chk("t1_wdata_e3", wdata, 8'h21);
    chk("t1_busy_gap", busy, 1);
    step(1);
    chk("t1_wr_e4", wr_tick, 0);
    chk("t1_busy_e4", busy, 0);

    // Back-to-back writes: 1,1,0 cadence and channel A period.
    push_cmd(13'h0021, 1);
    push_cmd(13'h010F, 1);
    push_cmd(13'h080F, 1);
    push_cmd(13'h0707, 1);
    step(11);
    #1;
    chk("t2_cadence", hist[12:0], 13'b1101101101100);
    chk("t2_period_a", {psg[1][3:0], psg[0]}, 12'hF21);
    chk("t2_mixer", psg[7], 8'h07);

    // Delay of 3 frames; tick on WAIT entry is ignored.
    step(2);
    push_cmd(13'h1003, 0);
    push = 1'b1; cmd = 13'h090F; exp_q.push_back(12'h90F); frame_tick = 1'b1;
    step(1);
    push = 1'b0; frame_tick = 1'b0;
    w0 = n_writes;
    repeat (2) begin
      step(99);
      frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    end
    step(50);
    chk("t3_hold_writes", n_writes, w0);
    chk("t3_hold_busy", busy, 1);
    step(49);
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
    chk("t3_wr_t0", wr_tick, 0);
    step(1);
    chk("t3_wr_t1", wr_tick, 0);
    step(1);
    chk("t3_wr_t2", wr_tick, 1);
    chk("t3_a0_t2", a0, 0);
    chk("t3_reg_t2", wdata, 8'h09);
    step(3);

    // Zero delay is consumed without waiting.
    push_cmd(13'h1000, 0);
    push_cmd(13'h0255, 1);
    step(2);
    chk("t3z_wr", wr_tick, 1);
    chk("t3z_a0", a0, 0);
    chk("t3z_reg", wdata, 8'h02);
    step(4);

    // Overflow while blocked in a long WAIT, then flush.
    push_cmd(13'h10C8, 0);
    step(2);
    for (int i = 0; i < DEPTH + 1; i++) push_cmd({1'b0, i[3:0], i[7:0]}, 0);
    chk("t4_full", full, 1);
    chk("t4_overflow", overflow, 1);
    step(3);
    chk("t4_overflow_sticky", overflow, 1);
    flush = 1'b1; step(1); flush = 1'b0;
    chk("t4_overflow_clr", overflow, 0);
    chk("t4_empty", empty, 1);
    chk("t4_full_clr", full, 0);
    chk("t4_busy", busy, 0);
    w0 = n_writes;
    step(20);
    chk("t4_no_writes", n_writes, w0);

    // Flush during the address phase: the pair completes, queue is dropped,
    // and a push coincident with flush is discarded.
    push_cmd(13'h0333, 1);
    push_cmd(13'h0444, 0);
    push_cmd(13'h0555, 0);
    chk("t5_addr_wr", wr_tick, 1);
    chk("t5_addr_a0", a0, 0);
    chk("t5_addr_reg", wdata, 8'h03);
    flush = 1'b1; push = 1'b1; cmd = 13'h0666;
    step(1);
    flush = 1'b0; push = 1'b0;
    chk("t5_data_wr", wr_tick, 1);
    chk("t5_data_a0", a0, 1);
    chk("t5_data_val", wdata, 8'h33);
    chk("t5_empty", empty, 1);
    step(1);
    chk("t5_wr_after", wr_tick, 0);
    chk("t5_busy_after", busy, 0);
    step(10);

    // Reset during the data phase drops outputs immediately.
    push_cmd(13'h0512, 1);
    push_cmd(13'h0613, 0);
    step(2);
    chk("t6_data_wr", wr_tick, 1);
    chk("t6_data_a0", a0, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_wr", wr_tick, 0);
    chk("t6_rst_a0", a0, 0);
    chk("t6_rst_wdata", wdata, 0);
    chk("t6_rst_empty", empty, 1);
    @(negedge clk);
    reset = 1'b0;
    step(2);

`ifdef AY_WRITE_SEQ_SHADOW_EN
    push_cmd(13'h0D02, 1);
    step(5);
    shadow_addr = 4'd13;
    #1 chk("shadow_r13", shadow_data, 8'h02);
    shadow_addr = 4'd6;
    #1 chk("shadow_r6", shadow_data, 8'h00);
`endif

    step(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
